key_expansion_inverse: RTL and testbench
========================================

// Module: key_expansion_inverse
// PURPOSE
//  Iterative inverse AES-128 key schedule: takes the final round key (round Nr) and walks the
//  schedule backwards, emitting round keys Nr, Nr-1, ..., 0 one per beat.
//  Decryption-side counterpart of the forward key expansion pipeline. Lets the inverse cipher
//  generate round keys on the fly, in decrypt order, without storing the full schedule.
//  One 4-byte S-box is shared across steps; one step per accepted output beat.
// PARAMETERS
//  KEY_LENGTH   128  key / round-key width; only 128 supported
//  WORD_LENGTH  32   schedule word width
//  Nb           4    words per round key
//  Nr           10   number of rounds; last round key index
// PORTS
//  clk        in   1    clock; all logic on posedge
//  reset      in   1    synchronous, active-high
//  i_valid    in   1    last_key valid
//  i_ready    out  1    block idle, can accept last_key
//  last_key   in   128  round-Nr key {w[4Nr],..,w[4Nr+3]}; w[4Nr] in [127:96]
//  o_valid    out  1    round_key / round_idx valid
//  o_ready    in   1    consumer accepts current beat
//  round_key  out  128  current round key, same word order as last_key
//  round_idx  out  4    index of round_key (Nr down to 0)
//  o_last     out  1    high with o_valid when round_idx==0
// BEHAVIOUR
//  Reset values: i_ready=1, o_valid=0, o_last=0, round_key=0, round_idx=0; state=IDLE.
//  States:
//   - IDLE: i_ready=1. On i_valid: key_reg<=last_key, round_idx<=Nr, go to EMIT.
//   - EMIT: i_ready=0, o_valid=1, round_key=key_reg.
//     - o_valid&&o_ready with round_idx!=0: key_reg<=prev(key_reg), round_idx<=round_idx-1.
//     - o_valid&&o_ready with round_idx==0: go to IDLE, o_valid=0 next cycle.
//     - !o_ready: hold round_key/round_idx stable (no step).
//  Latency: first beat (round Nr) valid the cycle after acceptance. Full throughput 1 key/cycle
//  under continuous o_ready: 11 beats total. i_ready returns 1 the cycle after the round-0 beat.
//  Step prev(), with current words w0..w3 of round r:
//   - p3=w3^w2, p2=w2^w1, p1=w1^w0
//   - p0=w0^SubWord(RotWord(p3))^{Rcon[r],24'h0}
//   - RotWord: {b1,b2,b3,b0}; SubWord: forward AES S-box per byte
//   - Rcon[1..10]=01,02,04,08,10,20,40,80,1b,36; indexed by the current round_idx, not a register chain
//  All XOR 32-bit, no width growth; prev() is combinational from key_reg, registered on handshake.
//  i_valid while not IDLE: ignored, last_key not sampled.
//  reset mid-walk: abort immediately, reset values next cycle, no further beats.
//  o_last combinational from (state==EMIT && round_idx==0).
// TESTING
//  1. FIPS-197 A.1: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, o_ready=1 -> beat0 idx10=last_key;
//     beat1 idx9=ac7766f319fadc2128d12941575c006e; idx1=a0fafe1788542cb123a339392a6c7605;
//     idx0=2b7e151628aed2a6abf7158809cf4f3c, o_last=1; 11 consecutive beats.
//  2. Backpressure: o_ready toggled randomly -> same 11 keys in order. Held key and idx stable
//     while o_valid&&!o_ready; no beats skipped or duplicated.
//  3. i_valid pulsed with a different key during EMIT -> ignored; sequence from test 1 unchanged.
//     i_ready=0 until the cycle after the idx0 beat.
//  4. reset asserted after idx6 beat -> next cycle o_valid=0, i_ready=1; a new last_key then
//     restarts cleanly at idx10.
//  5. Cross-check: 20 random keys expanded by a forward reference model; feed round-10 word ->
//     all 11 outputs match the model; back-to-back requests accepted 1 cycle after each o_last.

Source files
------------

// File: rtl/key_expansion_inverse.sv
// rtl/key_expansion_inverse.sv - inverse AES-128 key schedule, emits round keys Nr down to 0
// One shared 4-byte S-box; each accepted beat steps the schedule back one round.

module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_pos;

  // Entry 0 sits in the most significant byte of the table.
  assign w_pos  = 11'd2047 - {i_byte, 3'b000};
  assign o_byte = SBOX[w_pos -: 8];
endmodule

module key_expansion_inverse #(
  parameter int KEY_LENGTH  = 128,
  parameter int WORD_LENGTH = 32,
  parameter int Nb          = 4,
  parameter int Nr          = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [KEY_LENGTH-1:0] last_key,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [KEY_LENGTH-1:0] round_key,
  output logic [3:0]            round_idx,
  output logic                  o_last
);
  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [KEY_LENGTH-1:0]  r_key;
  logic [3:0]             r_idx;
  logic                   w_load;
  logic                   w_step;

  logic [WORD_LENGTH-1:0] w_w [Nb];
  logic [WORD_LENGTH-1:0] w_p0, w_p1, w_p2, w_p3;
  logic [WORD_LENGTH-1:0] w_rot;
  logic [WORD_LENGTH-1:0] w_sub;
  logic [7:0]             w_rcon;
  logic [KEY_LENGTH-1:0]  w_prev;

  for (genvar gi = 0; gi < Nb; gi++) begin : g_words
    assign w_w[gi] = r_key[KEY_LENGTH-1-gi*WORD_LENGTH -: WORD_LENGTH];
  end

  assign w_p3  = w_w[3] ^ w_w[2];
  assign w_p2  = w_w[2] ^ w_w[1];
  assign w_p1  = w_w[1] ^ w_w[0];
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  for (genvar gb = 0; gb < 4; gb++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte(w_rot[gb*8 +: 8]),
      .o_byte(w_sub[gb*8 +: 8])
    );
  end

  // Round constant follows the index of the key currently held, not a separate chain.
  always_comb begin
    w_rcon = 8'h00;
    case (r_idx)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_p0   = w_w[0] ^ w_sub ^ {w_rcon, 24'h000000};
  assign w_prev = {w_p0, w_p1, w_p2, w_p3};

  always_comb begin
    w_state_nxt = r_state;
    i_ready     = 1'b0;
    o_valid     = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        o_valid = 1'b1;
        if (o_ready) begin
          if (r_idx == 4'd0) w_state_nxt = S_IDLE;
          else               w_step      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_key <= last_key;
        r_idx <= 4'(Nr);
      end else if (w_step) begin
        r_key <= w_prev;
        r_idx <= r_idx - 4'd1;
      end
    end
  end

  assign round_key = r_key;
  assign round_idx = r_idx;
  assign o_last    = (r_state == S_EMIT) && (r_idx == 4'd0);
endmodule

// File: tb/tb_key_expansion_inverse.sv
// tb/tb_key_expansion_inverse.sv - bench for key_expansion_inverse against a forward-schedule model
module tb_key_expansion_inverse;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [127:0] last_key = '0;
  logic         o_valid;
  logic         o_ready = 1'b1;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         o_last;

  always #5 clk = ~clk;

  key_expansion_inverse dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
    .last_key(last_key), .o_valid(o_valid), .o_ready(o_ready),
    .round_key(round_key), .round_idx(round_idx), .o_last(o_last)
  );

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   idx;
  } beat_t;

  beat_t        exp_q[$];
  logic [7:0]   sbox_m [256];
  logic [127:0] rk [11];
  int           total = 0;
  int           bad = 0;
  bit           check_en = 1'b0;
  bit           rand_ready = 1'b0;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(posedge clk) begin
    #1;
    o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("o_valid", 128'(o_valid), 128'(exp_q.size() > 0));
      check("i_ready", 128'(i_ready), 128'(exp_q.size() == 0));
      if (exp_q.size() > 0) begin
        check("round_key", round_key, exp_q[0].key);
        check("round_idx", 128'(round_idx), 128'(exp_q[0].idx));
        check("o_last", 128'(o_last), 128'(exp_q[0].idx == 4'd0));
        if (o_valid && o_ready) void'(exp_q.pop_front());
      end else begin
        check("o_last_idle", 128'(o_last), 128'(0));
      end
    end
  end

  // Expands key0, offers round 10 once the block is ready, and queues the 11 expected beats.
  task automatic feed(input logic [127:0] key0, output int n_wait);
    n_wait = 0;
    expand(key0);
    while (i_ready !== 1'b1 && n_wait < 300) begin
      @(posedge clk); #1;
      n_wait++;
    end
    check("ready_before_feed", 128'(i_ready), 128'(1));
    if (i_ready === 1'b1) begin
      i_valid  = 1'b1;
      last_key = rk[10];
      @(posedge clk); #1;
      i_valid = 1'b0;
      for (int r = 10; r >= 0; r--) exp_q.push_back('{key: rk[r], idx: 4'(r)});
      check("first_valid", 128'(o_valid), 128'(1));
      check("first_idx", 128'(round_idx), 128'(10));
      check("first_key", round_key, rk[10]);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("walk_done", 128'(exp_q.size()), 128'(0));
  endtask

  int n;
  int found;

  initial begin
    init_sbox();
    expand(FIPS_KEY);
    check("model_rk10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("model_rk9", rk[9], 128'hac7766f319fadc2128d12941575c006e);
    check("model_rk1", rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_sbox00", 128'(sbox_m[0]), 128'h63);
    check("model_sbox53", 128'(sbox_m[8'h53]), 128'hed);

    repeat (2) @(posedge clk);
    #1;
    check("rst_i_ready", 128'(i_ready), 128'(1));
    check("rst_o_valid", 128'(o_valid), 128'(0));
    check("rst_o_last", 128'(o_last), 128'(0));
    check("rst_round_key", round_key, 128'(0));
    check("rst_round_idx", 128'(round_idx), 128'(0));
    reset = 1'b0;
    check_en = 1'b1;

    // Known-answer walk at full throughput.
    feed(FIPS_KEY, n);
    wait_idle(n);
    check("walk_cycles", 128'(n), 128'(11));
    check("round0_key", round_key, FIPS_KEY);

    // Random backpressure.
    rand_ready = 1'b1;
    feed(FIPS_KEY, n);
    wait_idle(n);
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // Intruding request while emitting.
    feed(FIPS_KEY, n);
    @(posedge clk); #1;
    i_valid  = 1'b1;
    last_key = 128'h00112233445566778899aabbccddeeff;
    repeat (2) @(posedge clk);
    #1;
    i_valid = 1'b0;
    wait_idle(n);

    // Reset in the middle of a walk.
    feed(FIPS_KEY, n);
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      @(negedge clk);
      if (o_valid && o_ready && round_idx == 4'd6) found = 1;
    end
    check("saw_idx6", 128'(found), 128'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    check("midrst_o_valid", 128'(o_valid), 128'(0));
    check("midrst_i_ready", 128'(i_ready), 128'(1));
    check("midrst_round_idx", 128'(round_idx), 128'(0));
    check("midrst_round_key", round_key, 128'(0));
    feed(FIPS_KEY, n);
    wait_idle(n);

    // Random keys back to back.
    for (int k = 0; k < 20; k++) begin
      feed({$urandom, $urandom, $urandom, $urandom}, n);
      if (k > 0) check("b2b_accept_gap", 128'(n), 128'(11));
    end
    wait_idle(n);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
